ahb_dma_addr_gen: RTL and testbench
===================================

Name: ahb_dma_addr_gen

Overview:
Parametrised, registered DMA channel address generator that replaces the combinational split-carry incrementer. Per transfer it loads a start address, beat size and mode, then steps the address once per accepted AHB beat. Step modes are increment, decrement, fixed and power-of-two wrap (circular buffer). It also counts the remaining beats and flags the last beat, completion, 1 KB boundary crossings and illegal configurations. One instance sits in each DMA channel, between the channel register file and the AHB master FSM.

Parameters:
ADDR_W, 32, address width in bits.
SPLIT, 16, carry-split point of the address adder (lower SPLIT bits plus carry into the upper part); must satisfy 11 <= SPLIT < ADDR_W.
CNT_W, 16, width of the beat counter and the wrap length.
MAX_SIZE, 2, largest legal size_i (log2 bytes); 2 means a 32-bit bus.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
load_i  in  1  capture the configuration and start a transfer.
start_addr_i  in  ADDR_W  first beat address.
size_i  in  3  beat size; increment is (1 << size_i) bytes.
mode_i  in  2  00 increment, 01 decrement, 10 fixed, 11 wrap.
wrap_len_i  in  CNT_W  wrap window in bytes; used in mode 11 only.
beats_i  in  CNT_W  number of beats in the transfer.
step_i  in  1  current beat accepted by the bus; advance.
abort_i  in  1  cancel the transfer.
addr_o  out  ADDR_W  current beat address (registered).
active_o  out  1  transfer in progress.
last_o  out  1  current beat is the final beat.
done_o  out  1  one-cycle pulse after the final step.
kb_cross_o  out  1  the next step crosses a 1 KB boundary.
err_o  out  1  sticky configuration error; cleared by the next legal load.

Behaviour:
- Reset values: addr_o = 0, active_o = 0, last_o = 0, done_o = 0, kb_cross_o = 0, err_o = 0. FSM in IDLE, beat counter 0.
- FSM states: IDLE, ACTIVE, DONE.
- Priority, highest first: rst > load_i > abort_i > step_i.
- load_i is accepted in any state and restarts the transfer (reload on the fly). Checks on load:
  - size_i > MAX_SIZE.
  - start_addr_i not aligned to (1 << size_i).
  - beats_i == 0.
  - mode 11 with wrap_len_i not a power of two, or wrap_len_i < (1 << size_i).
- Illegal load: err_o = 1, FSM goes to IDLE, addr_o is unchanged.
- Legal load: addr_o = start_addr_i, counter = beats_i, err_o = 0, FSM goes to ACTIVE on the next edge.
- ACTIVE with step_i: addr_o updates on the next edge (1-cycle latency) and the counter decrements.
  - Increment: addr + inc, modulo 2^ADDR_W.
  - Decrement: addr - inc, modulo 2^ADDR_W.
  - Fixed: addr unchanged.
  - Wrap: low bits = (addr + inc) & (wrap_len - 1); high bits held at the base address, i.e. start_addr_i & ~(wrap_len - 1) captured at load.
- Address adder: the lower SPLIT bits are computed with carry-out; the carry (or borrow) is added into bits ADDR_W-1:SPLIT. The result must equal a full-width add.
- last_o = active_o && counter == 1.
- step_i with counter == 1: go to DONE, done_o = 1 for exactly one cycle, then IDLE. addr_o holds the last address.
- step_i in IDLE or DONE: ignored.
- abort_i in ACTIVE: go to IDLE next edge, no done_o, addr_o holds.
- active_o = (state == ACTIVE).
- kb_cross_o is combinational from registered state and is 0 unless ACTIVE:
  - Increment: addr_o[9:0] + inc > 1023.
  - Decrement: addr_o[9:0] < inc.
  - Fixed or wrap: 0.
- load_i and step_i in the same cycle: load wins and the step is dropped.

Decomposition:
- Package ahb_dma_pkg holds:
  - enum dma_addr_mode_e {INC, DEC, FIX, WRAP}
  - enum addr_gen_state_e
  - localparam KB_BITS = 10
- Sub-module ahb_dma_addr_adder (ADDR_W, SPLIT): the parametrised split carry/borrow add/sub datapath, reused by other DMA blocks.

Test Plan:
- Increment across the split: load 0x0000_FFFC, size 2, beats 3, step x3 -> addr 0x0000_FFFC, 0x0001_0000, 0x0001_0004; last_o on the third beat; done_o one cycle after the third step.
- Decrement and address roll-under: load 0x0000_0002, size 1, mode DEC, beats 2 -> addr 0x0000_0002 then 0x0000_0000; kb_cross_o = 0 at 0x2 and 1 at 0x0.
- Wrap: load 0x1000_003C, size 2, wrap 64, beats 3 -> addr 0x1000_003C, 0x1000_0000, 0x1000_0004.
- Errors: load a misaligned address 0x0000_0003 with size 2 -> err_o = 1, active_o = 0. Load with size 3 -> err_o = 1. Load with wrap 48 in mode WRAP -> err_o = 1. A following legal load -> err_o = 0.
- Load, step and abort priority: load 0x0000_03FC, size 2, beats 4 -> kb_cross_o = 1. Assert load and step in the same cycle -> addr reloads and the counter is unchanged. abort_i mid-transfer -> IDLE, no done_o.
- Reset mid-transfer: assert rst asynchronously in ACTIVE -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ahb_dma_pkg.sv
// Shared types for the DMA channel address path: step modes, generator states
// and the 1 KB boundary width used for AHB burst-crossing detection.
package ahb_dma_pkg;

   typedef enum logic [1:0] {
      INC  = 2'b00,
      DEC  = 2'b01,
      FIX  = 2'b10,
      WRAP = 2'b11
   } dma_addr_mode_e;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACTIVE = 2'b01,
      DONE   = 2'b10
   } addr_gen_state_e;

   localparam int KB_BITS = 10;

endpackage

// File: rtl/ahb_dma_addr_adder.sv
// Split carry/borrow adder: low SPLIT bits produce a carry (or borrow) that is
// folded into the upper slice, giving the same result as a full-width add/sub.
module ahb_dma_addr_adder #(
   parameter int ADDR_W = 32,
   parameter int SPLIT  = 16
) (
   input  logic [ADDR_W-1:0] a,
   input  logic [ADDR_W-1:0] b,
   input  logic              sub,
   output logic [ADDR_W-1:0] sum
);

   logic [SPLIT:0]        lo;
   logic [ADDR_W-SPLIT-1:0] hi;

   always_comb begin
      lo = '0;
      hi = '0;
      if (sub) begin
         // bit SPLIT of the widened difference is the borrow out of the low slice
         lo = {1'b0, a[SPLIT-1:0]} - {1'b0, b[SPLIT-1:0]};
         hi = a[ADDR_W-1:SPLIT] - b[ADDR_W-1:SPLIT] - (ADDR_W-SPLIT)'(lo[SPLIT]);
      end else begin
         lo = {1'b0, a[SPLIT-1:0]} + {1'b0, b[SPLIT-1:0]};
         hi = a[ADDR_W-1:SPLIT] + b[ADDR_W-1:SPLIT] + (ADDR_W-SPLIT)'(lo[SPLIT]);
      end
   end

   assign sum = {hi, lo[SPLIT-1:0]};

endmodule

// File: rtl/ahb_dma_addr_gen.sv
// Per-channel DMA address generator: captures a transfer on load, then steps the
// address once per accepted AHB beat and tracks remaining beats.
//
//   state  | meaning
//   IDLE   | no transfer; waiting for a legal load
//   ACTIVE | transfer in progress; addr_o is the current beat address
//   DONE   | final beat accepted; done_o pulses for this one cycle
module ahb_dma_addr_gen
   import ahb_dma_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int SPLIT    = 16,
   parameter int CNT_W    = 16,
   parameter int MAX_SIZE = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] start_addr_i,
   input  logic [2:0]        size_i,
   input  logic [1:0]        mode_i,
   input  logic [CNT_W-1:0]  wrap_len_i,
   input  logic [CNT_W-1:0]  beats_i,
   input  logic              step_i,
   input  logic              abort_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              active_o,
   output logic              last_o,
   output logic              done_o,
   output logic              kb_cross_o,
   output logic              err_o
);

   addr_gen_state_e  state;
   dma_addr_mode_e   mode;
   logic [CNT_W-1:0] cnt;
   logic [ADDR_W-1:0] inc;
   logic [ADDR_W-1:0] wrap_mask;
   logic [ADDR_W-1:0] wrap_base;
   logic [ADDR_W-1:0] next_sum;
   logic [ADDR_W-1:0] next_addr;

   logic [ADDR_W-1:0] ld_inc;
   logic [CNT_W-1:0]  ld_wrap_m1;
   logic [ADDR_W-1:0] ld_mask;
   logic              ld_pow2;
   logic              ld_err;
   logic [KB_BITS:0]  kb_sum;

   always_comb begin
      ld_inc     = ADDR_W'(1) << size_i;
      ld_wrap_m1 = wrap_len_i - CNT_W'(1);
      ld_mask    = ADDR_W'(ld_wrap_m1);
      ld_pow2    = (wrap_len_i != '0) && ((wrap_len_i & ld_wrap_m1) == '0);
      ld_err     = (size_i > 3'(MAX_SIZE))
                || ((start_addr_i & (ld_inc - ADDR_W'(1))) != '0)
                || (beats_i == '0)
                || ((dma_addr_mode_e'(mode_i) == WRAP)
                    && (!ld_pow2 || (ADDR_W'(wrap_len_i) < ld_inc)));
   end

   ahb_dma_addr_adder #(
      .ADDR_W (ADDR_W),
      .SPLIT  (SPLIT)
   ) u_adder (
      .a   (addr_o),
      .b   (inc),
      .sub (mode == DEC),
      .sum (next_sum)
   );

   always_comb begin
      next_addr = addr_o;
      case (mode)
         INC, DEC: next_addr = next_sum;
         WRAP:     next_addr = wrap_base | (next_sum & wrap_mask);
         default:  next_addr = addr_o;
      endcase
   end

   assign kb_sum     = {1'b0, addr_o[KB_BITS-1:0]} + (KB_BITS+1)'(inc);
   assign kb_cross_o = active_o
                    && (((mode == INC) && kb_sum[KB_BITS])
                        || ((mode == DEC) && (ADDR_W'(addr_o[KB_BITS-1:0]) < inc)));
   assign last_o     = active_o && (cnt == CNT_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mode      <= INC;
         cnt       <= '0;
         inc       <= '0;
         wrap_mask <= '0;
         wrap_base <= '0;
         addr_o    <= '0;
         active_o  <= 1'b0;
         done_o    <= 1'b0;
         err_o     <= 1'b0;
      end else if (load_i) begin
         done_o <= 1'b0;
         if (ld_err) begin
            state    <= IDLE;
            active_o <= 1'b0;
            err_o    <= 1'b1;
         end else begin
            state     <= ACTIVE;
            active_o  <= 1'b1;
            err_o     <= 1'b0;
            mode      <= dma_addr_mode_e'(mode_i);
            cnt       <= beats_i;
            inc       <= ld_inc;
            wrap_mask <= ld_mask;
            wrap_base <= start_addr_i & ~ld_mask;
            addr_o    <= start_addr_i;
         end
      end else begin
         case (state)
            ACTIVE: begin
               if (abort_i) begin
                  state    <= IDLE;
                  active_o <= 1'b0;
               end else if (step_i) begin
                  // the final step leaves addr_o on the last beat address
                  if (cnt == CNT_W'(1)) begin
                     state    <= DONE;
                     active_o <= 1'b0;
                     done_o   <= 1'b1;
                  end else begin
                     addr_o <= next_addr;
                     cnt    <= cnt - CNT_W'(1);
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               done_o <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_dma_addr_gen.sv
// Bench for ahb_dma_addr_gen: directed scenarios plus random traffic, every
// cycle compared against a transfer-level reference model.
module tb_ahb_dma_addr_gen;

   localparam int ADDR_W = 32;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              load_i;
   logic [ADDR_W-1:0] start_addr_i;
   logic [2:0]        size_i;
   logic [1:0]        mode_i;
   logic [CNT_W-1:0]  wrap_len_i;
   logic [CNT_W-1:0]  beats_i;
   logic              step_i;
   logic              abort_i;
   logic [ADDR_W-1:0] addr_o;
   logic              active_o;
   logic              last_o;
   logic              done_o;
   logic              kb_cross_o;
   logic              err_o;

   always #5 clk = ~clk;

   ahb_dma_addr_gen #(
      .ADDR_W   (32),
      .SPLIT    (16),
      .CNT_W    (16),
      .MAX_SIZE (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .load_i       (load_i),
      .start_addr_i (start_addr_i),
      .size_i       (size_i),
      .mode_i       (mode_i),
      .wrap_len_i   (wrap_len_i),
      .beats_i      (beats_i),
      .step_i       (step_i),
      .abort_i      (abort_i),
      .addr_o       (addr_o),
      .active_o     (active_o),
      .last_o       (last_o),
      .done_o       (done_o),
      .kb_cross_o   (kb_cross_o),
      .err_o        (err_o)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: transfer described by remaining beat count and flags
   logic [31:0] m_addr;
   int unsigned m_left;
   bit          m_active, m_done, m_err;
   int unsigned m_mode, m_inc, m_wlen;
   logic [31:0] m_base;

   task automatic model_reset();
      m_addr = 0; m_left = 0; m_active = 0; m_done = 0; m_err = 0;
      m_mode = 0; m_inc = 0; m_wlen = 1; m_base = 0;
   endtask

   task automatic model_edge();
      bit ok;
      int unsigned sz, wl;
      if (load_i) begin
         sz = int'(size_i);
         wl = int'(wrap_len_i);
         ok = (sz <= 2) && (int'(beats_i) != 0);
         if (ok) ok = (start_addr_i % (32'd1 << sz)) == 0;
         if (ok && mode_i == 2'd3) ok = ($countones(wl) == 1) && (wl >= (1 << sz));
         m_done = 0;
         if (!ok) begin
            m_err = 1; m_active = 0;
         end else begin
            m_err = 0; m_active = 1;
            m_addr = start_addr_i; m_left = int'(beats_i);
            m_mode = int'(mode_i); m_inc = 1 << sz; m_wlen = wl;
            if (m_mode == 3) m_base = start_addr_i - (start_addr_i % wl);
         end
      end else if (m_done) begin
         m_done = 0;
      end else if (m_active) begin
         if (abort_i) m_active = 0;
         else if (step_i) begin
            if (m_left == 1) begin
               m_active = 0; m_done = 1;
            end else begin
               m_left--;
               case (m_mode)
                  0: m_addr = m_addr + m_inc;
                  1: m_addr = m_addr - m_inc;
                  3: m_addr = m_base + ((m_addr + m_inc) % m_wlen);
                  default: ;
               endcase
            end
         end
      end
   endtask

   function automatic bit exp_kb();
      int unsigned off;
      off = m_addr % 1024;
      if (!m_active) return 0;
      if (m_mode == 0) return (off + m_inc) > 1023;
      if (m_mode == 1) return off < m_inc;
      return 0;
   endfunction

   task automatic check_all();
      check("addr",   addr_o, m_addr);
      check("active", 32'(active_o), 32'(m_active));
      check("last",   32'(last_o), 32'(m_active && m_left == 1));
      check("done",   32'(done_o), 32'(m_done));
      check("kb",     32'(kb_cross_o), 32'(exp_kb()));
      check("err",    32'(err_o), 32'(m_err));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic do_load(input logic [31:0] a, input logic [2:0] s, input logic [1:0] m,
                          input logic [15:0] w, input logic [15:0] b);
      load_i = 1; start_addr_i = a; size_i = s; mode_i = m; wrap_len_i = w; beats_i = b;
      cycle();
      load_i = 0;
   endtask

   initial begin
      rst = 1; load_i = 0; start_addr_i = 0; size_i = 0; mode_i = 0;
      wrap_len_i = 0; beats_i = 0; step_i = 0; abort_i = 0;
      model_reset();
      @(posedge clk); #1;
      check_all();
      rst = 0;

      // increment across the carry split
      do_load(32'h0000_FFFC, 3'd2, 2'd0, 16'd0, 16'd3);
      check("inc_a0", addr_o, 32'h0000_FFFC);
      step_i = 1;
      cycle(); check("inc_a1", addr_o, 32'h0001_0000);
      cycle(); check("inc_a2", addr_o, 32'h0001_0004); check("inc_last", 32'(last_o), 1);
      cycle(); check("inc_done", 32'(done_o), 1); check("inc_hold", addr_o, 32'h0001_0004);
      step_i = 0;
      cycle(); check("inc_done_pulse", 32'(done_o), 0);

      // decrement down to zero
      do_load(32'h0000_0002, 3'd1, 2'd1, 16'd0, 16'd2);
      check("dec_kb0", 32'(kb_cross_o), 0);
      step_i = 1;
      cycle(); check("dec_a1", addr_o, 32'h0); check("dec_kb1", 32'(kb_cross_o), 1);
      cycle(); check("dec_done", 32'(done_o), 1);
      step_i = 0;
      cycle();

      // wrap in a 64-byte window
      do_load(32'h1000_003C, 3'd2, 2'd3, 16'd64, 16'd3);
      step_i = 1;
      cycle(); check("wrap_a1", addr_o, 32'h1000_0000);
      cycle(); check("wrap_a2", addr_o, 32'h1000_0004);
      cycle(); step_i = 0;
      cycle();

      // illegal configurations
      do_load(32'h0000_0003, 3'd2, 2'd0, 16'd0, 16'd1);
      check("err_align", 32'(err_o), 1); check("err_idle", 32'(active_o), 0);
      do_load(32'h0000_0000, 3'd3, 2'd0, 16'd0, 16'd1);
      check("err_size", 32'(err_o), 1);
      do_load(32'h0000_0040, 3'd2, 2'd3, 16'd48, 16'd2);
      check("err_wrap48", 32'(err_o), 1);
      do_load(32'h0000_0040, 3'd2, 2'd0, 16'd0, 16'd2);
      check("err_clear", 32'(err_o), 0); check("err_clr_act", 32'(active_o), 1);

      // priority: load over step, abort mid-transfer
      do_load(32'h0000_03FC, 3'd2, 2'd0, 16'd0, 16'd4);
      check("kb_3fc", 32'(kb_cross_o), 1);
      step_i = 1;
      cycle(); check("pri_a1", addr_o, 32'h0000_0400);
      do_load(32'h0000_0100, 3'd2, 2'd0, 16'd0, 16'd3);
      check("pri_reload", addr_o, 32'h0000_0100); check("pri_cnt", 32'(last_o), 0);
      step_i = 0; abort_i = 1;
      cycle(); check("abort_idle", 32'(active_o), 0);
      abort_i = 0;
      cycle(); check("abort_nodone", 32'(done_o), 0);

      // asynchronous reset while active
      do_load(32'h2000_0010, 3'd2, 2'd0, 16'd0, 16'd5);
      step_i = 1;
      cycle();
      step_i = 0;
      check("pre_rst_act", 32'(active_o), 1);
      #2 rst = 1;
      #1 model_reset();
      check_all();
      #1 rst = 0;

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         load_i = ($urandom_range(0, 9) == 0);
         if (load_i) begin
            size_i = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            mode_i = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
               0: start_addr_i = $urandom;
               1: start_addr_i = 32'h0000_FFF0 + 32'($urandom_range(0, 15));
               2: start_addr_i = 32'h0000_03F0 + 32'($urandom_range(0, 15));
               3: start_addr_i = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
               default: start_addr_i = 32'h0001_0000 + 32'($urandom_range(0, 15));
            endcase
            if ($urandom_range(0, 7) != 0)
               start_addr_i = start_addr_i & ~((32'd1 << size_i) - 32'd1);
            wrap_len_i = ($urandom_range(0, 5) == 0) ? 16'd48 : (16'd1 << $urandom_range(0, 8));
            beats_i = 16'($urandom_range(0, 6));
         end
         step_i  = ($urandom_range(0, 3) != 0);
         abort_i = ($urandom_range(0, 24) == 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
